// File: rtl/fft_frame_writer.sv
// fft_frame_writer: turns the FFT core output stream into bin magnitudes,
// writes them into the 4096 x 16 magnitude BRAM one frame slot at a time,
// and announces each completed frame (fhead/ready) to process_fft.
module fft_frame_writer #(
  parameter int BINS  = 1024,
  parameter int SLOTS = 4,
  parameter int DECIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [11:0] waddr,
  output logic [15:0] wdata,
  output logic        we,
  output logic [11:0] fhead,
  output logic        ready,
  output logic        error
);

  localparam int BIN_W  = $clog2(BINS);
  localparam int SLOT_W = $clog2(SLOTS);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BIN_W-1:0]  bin, bin_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic [7:0]        dec_cnt, dec_nxt;

  logic accept;
  logic last_bin;
  logic wr_beat;
  logic good_end;
  logic frame_err;

  // Pipeline stage 1: captured operands
  logic               p1_v, p1_last;
  logic [11:0]        p1_addr;
  logic signed [15:0] re_q, im_q;

  // Pipeline stage 2: squares
  logic               p2_v, p2_last;
  logic [11:0]        p2_addr;
  logic signed [31:0] sq_re, sq_im;

  // Pipeline stage 3: sum, drives the BRAM port
  logic               p3_last;
  logic [32:0]        sum;
  logic               sum_lo_unused;

  assign accept   = s_tvalid & s_tready;
  assign last_bin = (bin == BIN_W'(BINS - 1));

  // Frame controller: classify each accepted beat and plan bin/slot/decimation updates
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    slot_nxt  = slot;
    dec_nxt   = dec_cnt;
    wr_beat   = 1'b0;
    good_end  = 1'b0;
    frame_err = 1'b0;
    case (state)
      SYNC: begin
        if (accept && s_tlast) begin
          state_nxt = RUN;
          bin_nxt   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          wr_beat = (dec_cnt == 8'd0);
          if (last_bin) begin
            bin_nxt = '0;
            if (s_tlast) begin
              if (dec_cnt == 8'd0) begin
                good_end = 1'b1;
                slot_nxt = slot + SLOT_W'(1);
              end
              dec_nxt = (dec_cnt == 8'(DECIM - 1)) ? 8'd0 : dec_cnt + 8'd1;
            end else begin
              frame_err = 1'b1;
              state_nxt = DROP;
            end
          end else if (s_tlast) begin
            frame_err = 1'b1;
            bin_nxt   = '0;
          end else begin
            bin_nxt = bin + BIN_W'(1);
          end
        end
      end
      DROP: begin
        if (accept && s_tlast) begin
          state_nxt = RUN;
          bin_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        bin_nxt   = '0;
      end
    endcase
  end

  // Controller state, always-ready handshake and the framing-fault pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      bin      <= '0;
      slot     <= '0;
      dec_cnt  <= 8'd0;
      s_tready <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bin      <= bin_nxt;
      slot     <= slot_nxt;
      dec_cnt  <= dec_nxt;
      s_tready <= 1'b1;
      error    <= frame_err;
    end
  end

  // Three-stage magnitude pipeline carrying write address and end-of-frame tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_v    <= 1'b0;
      p1_last <= 1'b0;
      p1_addr <= '0;
      re_q    <= '0;
      im_q    <= '0;
      p2_v    <= 1'b0;
      p2_last <= 1'b0;
      p2_addr <= '0;
      sq_re   <= '0;
      sq_im   <= '0;
      we      <= 1'b0;
      p3_last <= 1'b0;
      waddr   <= '0;
      sum     <= '0;
    end else begin
      p1_v    <= wr_beat;
      p1_last <= good_end;
      p1_addr <= {slot, bin};
      re_q    <= s_tdata[15:0];
      im_q    <= s_tdata[31:16];
      p2_v    <= p1_v;
      p2_last <= p1_last;
      p2_addr <= p1_addr;
      sq_re   <= 32'(re_q) * 32'(re_q);
      sq_im   <= 32'(im_q) * 32'(im_q);
      we      <= p2_v;
      p3_last <= p2_last;
      waddr   <= p2_addr;
      sum     <= {1'b0, sq_re} + {1'b0, sq_im};
    end
  end

  // The upper half of the sum is the magnitude; overflow into bit 32 saturates
  assign wdata         = sum[32] ? 16'hFFFF : sum[31:16];
  assign sum_lo_unused = ^sum[15:0];

  // Announce a frame the cycle after its final write, holding fhead until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready <= 1'b0;
      fhead <= '0;
    end else begin
      ready <= we & p3_last;
      if (we && p3_last) begin
        fhead <= waddr & ~12'(BINS - 1);
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_writer.sv
// Bench for fft_frame_writer: two instances (DECIM=1 and DECIM=3) share one
// directed stimulus stream; a frame-level model predicts every output per cycle.
module tb_fft_frame_writer;

  localparam int BINS  = 1024;
  localparam int SLOTS = 4;
  localparam int MAXC  = 32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;

  logic        tr0, we0, rdy0, err0;
  logic [11:0] wa0, fh0;
  logic [15:0] wd0;
  logic        tr1, we1, rdy1, err1;
  logic [11:0] wa1, fh1;
  logic [15:0] wd1;

  fft_frame_writer #(.BINS(BINS), .SLOTS(SLOTS), .DECIM(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(tr0), .waddr(wa0), .wdata(wd0), .we(we0),
    .fhead(fh0), .ready(rdy0), .error(err0)
  );

  fft_frame_writer #(.BINS(BINS), .SLOTS(SLOTS), .DECIM(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(tr1), .waddr(wa1), .wdata(wd1), .we(we1),
    .fhead(fh1), .ready(rdy1), .error(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int chk_from = 1 << 30;
  int dec_of [2] = '{1, 3};

  // Expected outputs per cycle, filled in ahead of time by the model
  bit          e_trdy [MAXC];
  bit          e_rst  [MAXC];
  bit          e_we   [2][MAXC];
  logic [11:0] e_addr [2][MAXC];
  logic [15:0] e_data [2][MAXC];
  bit          e_rdy  [2][MAXC];
  logic [11:0] e_fh   [2][MAXC];
  bit          e_err  [2][MAXC];

  // Frame-level model state
  bit m_drop [2];
  int m_bin  [2];
  int m_slot [2];
  int m_dec  [2];

  // Observation logs gathered by the compare process
  logic [11:0] cur_fh [2] = '{12'h000, 12'h000};
  int          rdy_cnt [2];
  int          err_cnt [2];
  logic [15:0] mem [2][4096];
  logic [11:0] fhq0 [$];
  logic [11:0] fhq1 [$];
  bit          first_pend [2];
  logic [11:0] first_wa [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat_of(input longint s);
    logic [63:0] u;
    u = s;
    if (s >= 64'sh1_0000_0000) return 16'hFFFF;
    return u[31:16];
  endfunction

  function automatic logic [15:0] mag_of(input logic [15:0] re, input logic [15:0] im);
    longint r, i;
    r = longint'($signed(re));
    i = longint'($signed(im));
    return sat_of(r * r + i * i);
  endfunction

  function automatic logic [11:0] q0(input int i);
    return (i < fhq0.size()) ? fhq0[i] : 12'hEEE;
  endfunction

  function automatic logic [11:0] q1(input int i);
    return (i < fhq1.size()) ? fhq1[i] : 12'hEEE;
  endfunction

  // Apply the frame rules to one accepted beat of instance d, presented in cycle k
  task automatic modelBeat(input int d, input int k);
    logic [15:0] re, im;
    re = s_tdata[15:0];
    im = s_tdata[31:16];
    if (m_drop[d]) begin
      if (s_tlast) begin
        m_drop[d] = 1'b0;
        m_bin[d]  = 0;
      end
    end else begin
      if (m_dec[d] == 0) begin
        e_we[d][k+3]   = 1'b1;
        e_addr[d][k+3] = 12'(m_slot[d] * BINS + m_bin[d]);
        e_data[d][k+3] = mag_of(re, im);
      end
      if (m_bin[d] == BINS - 1) begin
        m_bin[d] = 0;
        if (s_tlast) begin
          if (m_dec[d] == 0) begin
            e_rdy[d][k+4] = 1'b1;
            e_fh[d][k+4]  = 12'(m_slot[d] * BINS);
            m_slot[d]     = (m_slot[d] + 1) % SLOTS;
          end
          m_dec[d] = (m_dec[d] + 1) % dec_of[d];
        end else begin
          e_err[d][k+1] = 1'b1;
          m_drop[d]     = 1'b1;
        end
      end else if (s_tlast) begin
        e_err[d][k+1] = 1'b1;
        m_bin[d]      = 0;
      end else begin
        m_bin[d]++;
      end
    end
  endtask

  // Predict consequences of the inputs just driven for cycle k
  task automatic modelStep(input int k);
    if (k + 5 >= MAXC) begin
      $display("[TB] FAIL cycle_budget: got %0d expected below %0d", k, MAXC - 5);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    if (!rst_n) begin
      e_trdy[k+1] = 1'b0;
      e_rst[k+1]  = 1'b1;
      for (int d = 0; d < 2; d++) begin
        for (int j = k + 1; j <= k + 4; j++) begin
          e_we[d][j]  = 1'b0;
          e_rdy[d][j] = 1'b0;
          e_err[d][j] = 1'b0;
        end
        m_drop[d] = 1'b0;
        m_bin[d]  = 0;
        m_slot[d] = 0;
        m_dec[d]  = 0;
      end
      if (chk_from > k + 1) chk_from = k + 1;
    end else begin
      e_trdy[k+1] = 1'b1;
      if (s_tvalid && e_trdy[k]) begin
        for (int d = 0; d < 2; d++) modelBeat(d, k);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic [15:0] re,
                               input logic [15:0] im, input logic rn);
    @(negedge clk);
    s_tvalid = v;
    s_tlast  = l;
    s_tdata  = {im, re};
    rst_n    = rn;
    modelStep(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h4321, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    idle(2);
  endtask

  // kind 0: constant 0x0100 real; kind 1: extreme values first; else a seeded ramp
  task automatic sendFrame(input int n, input int lastpos, input int kind, input int gap);
    logic [15:0] re, im;
    for (int i = 0; i < n; i++) begin
      if (kind == 0) begin
        re = 16'h0100;
        im = 16'h0000;
      end else if (kind == 1 && i == 0) begin
        re = 16'h8000;
        im = 16'h8000;
      end else if (kind == 1 && i == 1) begin
        re = 16'h7FFF;
        im = 16'h8000;
      end else begin
        re = 16'(i * kind * 13 + 5);
        im = 16'(kind * 101 - i * 7);
      end
      applyStimulus(1'b1, (i == lastpos), re, im, 1'b1);
      if (gap > 0 && (i % gap) == gap - 1) idle(1);
    end
  endtask

  task automatic clearLogs();
    for (int d = 0; d < 2; d++) begin
      rdy_cnt[d] = 0;
      err_cnt[d] = 0;
    end
    fhq0.delete();
    fhq1.delete();
  endtask

  task automatic cmpDut(input int d, input logic tr, input logic we, input logic [11:0] wa,
                        input logic [15:0] wd, input logic [11:0] fh, input logic rdy,
                        input logic err);
    int c;
    c = cyc;
    if (e_rst[c]) cur_fh[d] = 12'h000;
    if (e_rdy[d][c]) cur_fh[d] = e_fh[d][c];
    chk($sformatf("dut%0d.s_tready", d), 32'(tr), 32'(e_trdy[c]));
    chk($sformatf("dut%0d.we", d), 32'(we), 32'(e_we[d][c]));
    if (e_we[d][c]) begin
      chk($sformatf("dut%0d.waddr", d), 32'(wa), 32'(e_addr[d][c]));
      chk($sformatf("dut%0d.wdata", d), 32'(wd), 32'(e_data[d][c]));
    end else if (e_rst[c]) begin
      chk($sformatf("dut%0d.waddr_rst", d), 32'(wa), 32'h0);
      chk($sformatf("dut%0d.wdata_rst", d), 32'(wd), 32'h0);
    end
    chk($sformatf("dut%0d.ready", d), 32'(rdy), 32'(e_rdy[d][c]));
    chk($sformatf("dut%0d.error", d), 32'(err), 32'(e_err[d][c]));
    chk($sformatf("dut%0d.fhead", d), 32'(fh), 32'(cur_fh[d]));
    if (we === 1'b1) begin
      mem[d][wa] = wd;
      if (first_pend[d]) begin
        first_wa[d]   = wa;
        first_pend[d] = 1'b0;
      end
    end
    if (rdy === 1'b1) begin
      rdy_cnt[d]++;
      if (d == 0) fhq0.push_back(fh);
      else fhq1.push_back(fh);
    end
    if (err === 1'b1) err_cnt[d]++;
  endtask

  task automatic checkOutput();
    cmpDut(0, tr0, we0, wa0, wd0, fh0, rdy0, err0);
    cmpDut(1, tr1, we1, wa1, wd1, fh1, rdy1, err1);
  endtask

  // Compare process: sample both instances 1 time unit after every rising edge
  always @(posedge clk) begin
    #1;
    if (cyc >= chk_from) checkOutput();
  end

  initial begin
    chk("pin_mag_0100", 32'(mag_of(16'h0100, 16'h0000)), 32'h0001);
    chk("pin_mag_8000", 32'(mag_of(16'h8000, 16'h8000)), 32'h8000);
    chk("pin_mag_7fff", 32'(mag_of(16'h7FFF, 16'h8000)), 32'h7FFF);
    chk("pin_sat_bit32", 32'(sat_of(64'sh1_1234_0000)), 32'hFFFF);
    chk("pin_nosat", 32'(sat_of(64'sh0_ABCD_1234)), 32'hABCD);

    resetDut();
    clearLogs();

    // Constant 0x0100 frame: every bin magnitude is 1
    sendFrame(BINS, BINS - 1, 0, 0);
    idle(6);
    chk("r032_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
    chk("r032_fhead", 32'(q0(0)), 32'h000);
    chk("r032_mem_first", 32'(mem[0][0]), 32'h0001);
    chk("r032_mem_last", 32'(mem[0][1023]), 32'h0001);

    // Four more good frames, back to back, covering slot wrap
    sendFrame(BINS, BINS - 1, 3, 97);
    sendFrame(BINS, BINS - 1, 5, 0);
    sendFrame(BINS, BINS - 1, 7, 0);
    sendFrame(BINS, BINS - 1, 9, 0);
    idle(6);
    chk("r033_fh1", 32'(q0(1)), 32'h400);
    chk("r033_fh2", 32'(q0(2)), 32'h800);
    chk("r033_fh3", 32'(q0(3)), 32'hC00);
    chk("r033_fh4_wrap", 32'(q0(4)), 32'h000);
    chk("r033_dec3_cnt", 32'(rdy_cnt[1]), 32'd2);

    // Extreme operand frame lands in slot 1 of the DECIM=1 instance
    sendFrame(BINS, BINS - 1, 1, 0);
    idle(6);
    chk("r034_min_min", 32'(mem[0][12'h400]), 32'h8000);
    chk("r034_max_min", 32'(mem[0][12'h401]), 32'h7FFF);

    // Short frame then a good frame
    resetDut();
    clearLogs();
    sendFrame(501, 500, 11, 0);
    sendFrame(BINS, BINS - 1, 13, 0);
    idle(6);
    chk("r035_err_cnt", 32'(err_cnt[0]), 32'd1);
    chk("r035_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
    chk("r035_fhead", 32'(q0(0)), 32'h000);

    // Long frame then a good frame
    clearLogs();
    sendFrame(1100, 1099, 15, 0);
    sendFrame(BINS, BINS - 1, 17, 0);
    idle(6);
    chk("r036_err_cnt", 32'(err_cnt[0]), 32'd1);
    chk("r036_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
    chk("r036_fhead", 32'(q0(0)), 32'h400);

    // Six good frames from reset against DECIM=3
    resetDut();
    clearLogs();
    for (int f = 0; f < 6; f++) sendFrame(BINS, BINS - 1, 19 + 2 * f, 0);
    idle(6);
    chk("r037_dec3_ready_cnt", 32'(rdy_cnt[1]), 32'd2);
    chk("r037_dec3_fh0", 32'(q1(0)), 32'h000);
    chk("r037_dec3_fh1", 32'(q1(1)), 32'h400);
    chk("r037_dec1_ready_cnt", 32'(rdy_cnt[0]), 32'd6);

    // Reset pulse mid-frame at bin 600, then a fresh frame
    resetDut();
    clearLogs();
    sendFrame(600, -1, 23, 0);
    applyStimulus(1'b1, 1'b0, 16'h2222, 16'h3333, 1'b0);
    idle(8);
    chk("r038_no_ready", 32'(rdy_cnt[0]), 32'd0);
    chk("r038_no_error", 32'(err_cnt[0]), 32'd0);
    first_pend[0] = 1'b1;
    sendFrame(BINS, BINS - 1, 25, 0);
    idle(6);
    chk("r038_first_waddr", 32'(first_wa[0]), 32'h000);
    chk("r038_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
    chk("r038_fhead", 32'(q0(0)), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_writer.md
FFT_FRAME_WRITER -- requirements
Module: fft_frame_writer

Upstream stage of process_fft. Takes the FFT core output stream, computes bin magnitudes and writes them into the 4096 x 16 magnitude BRAM. Announces each completed frame to process_fft through fhead/ready.

Interface
REQ-001 Parameter BINS, default 1024, bins per frame, power of two.
REQ-002 Parameter SLOTS, default 4, frame slots in the BRAM; BINS*SLOTS SHALL equal 4096.
REQ-003 Parameter DECIM, default 1, write one frame in every DECIM accepted frames (range 1..255).
REQ-004 clk  in  1  sole clock, all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 s_tdata  in  32  FFT bin: [15:0] real, [31:16] imaginary, two's complement.
REQ-007 s_tvalid  in  1  bin valid.
REQ-008 s_tlast  in  1  marks the last bin of a frame.
REQ-009 s_tready  out  1  bin accepted when s_tvalid and s_tready are both high.
REQ-010 waddr  out  12  BRAM write address, {slot, bin}.
REQ-011 wdata  out  16  magnitude to write.
REQ-012 we  out  1  BRAM write enable.
REQ-013 fhead  out  12  base address of the most recently completed frame; drives process_fft fhead.
REQ-014 ready  out  1  one-cycle pulse, new frame complete; drives process_fft ready.
REQ-015 error  out  1  one-cycle pulse on a framing fault.

Function
REQ-016 s_tready SHALL be high every cycle outside reset; the block never back-pressures.
REQ-017 Magnitude SHALL be computed in three registered stages: capture re/im, signed 16x16 squares, 33-bit sum.
REQ-018 wdata SHALL equal sum[31:16]; if sum[32] is set, wdata SHALL saturate to 16'hFFFF.
REQ-019 A beat accepted at cycle N SHALL produce its we pulse at cycle N+3. Back-to-back beats produce back-to-back writes.
REQ-020 A bin counter (log2 BINS bits) SHALL count accepted beats from 0. waddr = {slot, bin} of the beat being written.
REQ-021 Frame controller states:
- SYNC: discard beats until s_tlast, then go to RUN with bin = 0.
- RUN: accept and write beats.
- DROP: discard beats until s_tlast, then go to RUN.
REQ-022 Good frame: s_tlast arrives on bin BINS-1 in RUN.
- ready pulses the cycle after that bin's write (N+4).
- In the same cycle fhead becomes {slot, zeros}.
- slot then increments modulo SLOTS.
REQ-023 Short frame (s_tlast on bin < BINS-1):
- error pulses at N+1.
- bin resets to 0, slot unchanged, no ready.
- The next frame overwrites the same slot.
REQ-024 Long frame (bin BINS-1 accepted without s_tlast):
- error pulses at N+1.
- FSM enters DROP; beats in DROP SHALL NOT write.
- slot unchanged, no ready.
REQ-025 Decimation counter:
- Counts good-length frames modulo DECIM.
- Frames with counter != 0 SHALL be consumed without asserting we, ready or advancing slot.
- The counter advances on every frame that would have been good.
REQ-026 With DECIM=1 every good frame is written.
REQ-027 Writes of a frame's final bins still in the pipeline SHALL complete even if the next frame's beats begin the following cycle.
REQ-028 fhead SHALL hold its value between ready pulses.

Reset
REQ-029 While rst_n = 0 at a clock edge, all of the following SHALL be 0 on the next cycle: s_tready, we, wdata, waddr, fhead, ready, error.
- bin, slot and decimation count SHALL be 0.
- FSM SHALL be RUN.
- Pipeline valid bits SHALL be cleared.
REQ-030 Reset mid-frame SHALL discard in-flight pipeline writes (we low from the next cycle) and produce no ready.
REQ-031 s_tready SHALL rise the cycle after rst_n returns high.

Verification
REQ-032 1024 beats of re=16'h0100, im=0, s_tlast on the last -> 1024 writes, waddr 0..1023, wdata 16'h0001; ready at the cycle after the last we; fhead = 0.
REQ-033 Four consecutive good frames -> fhead sequence 0x000, 0x400, 0x800, 0xC00. A fifth frame writes waddr 0x000..0x3FF again.
REQ-034 re=im=16'h8000 -> sum = 2^31, wdata 16'h8000. re=16'h7FFF, im=16'h8000 -> sum bit 32 clear, wdata 16'h7FFF. Force sum[32] through the arithmetic model -> wdata 16'hFFFF.
REQ-035 Frame with s_tlast on bin 500 -> error pulse, no ready. The next good frame is written at slot 0, fhead = 0.
REQ-036 Frame of 1100 beats -> error at bin 1023; beats 1024..1099 produce no we; the following frame is written normally.
REQ-037 DECIM=3, six good frames -> frames 0 and 3 written, ready pulses only twice, fhead = 0x000 then 0x400.
REQ-038 rst_n low for one cycle at bin 600 -> we low from the next cycle, no ready; a fresh frame after reset lands at waddr 0.
